// File: rtl/mem_line_responder_if.sv
// Cache-line memory bus between the cache initiators and the line responder.
// Request is level-held until the one-cycle mem_ready completion pulse.
interface mem_line_responder_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) ();
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_line_responder.sv
// Slow-memory line responder: one request at a time, fixed latency, 128-bit line array.
// Optional MEM_RESP_STATS_EN adds saturating read/write completion counters.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write, captures request
// WAIT  | latency down-counter running
// RESP  | mem_ready pulse; read data presented, write committed at end
// TURN  | dead cycle so the initiator can drop its request
module mem_line_responder #(
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 128,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  proc_reset_n,
   mem_line_responder_if.slave   mem,
   output logic                  proto_err
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [31:0]           stat_reads,
   output logic [31:0]           stat_writes
`endif
);

   generate
      if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
         $error("mem_line_responder: LATENCY must be in 1..255");
      end
   endgenerate

   localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

   state_t                state, state_nxt;
   logic [7:0]            cnt, cnt_nxt;
   logic                  capture;
   logic                  req_wr;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W-1:0]     rdata_q;
   logic                  rd_load;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DATA_W-1:0]     mem_array [2**DEPTH_LOG2];
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^mem.mem_addr[ADDR_W-1:DEPTH_LOG2];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (mem.mem_read || mem.mem_write) begin
               capture = 1'b1;
               if (LATENCY == 1) begin
                  state_nxt = RESP;
                  cnt_nxt   = 8'd0;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = LAT_LOAD;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 8'd1;
            if (cnt_nxt == 8'd0) state_nxt = RESP;
         end
         RESP:    state_nxt = TURN;
         TURN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read data is fetched on entry to RESP so it lines up with mem_ready.
   assign rd_idx  = capture ? mem.mem_addr[DEPTH_LOG2-1:0] : req_idx;
   assign rd_load = (state_nxt == RESP) && (state != RESP) &&
                    !(capture ? mem.mem_write : req_wr);

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         req_wr    <= 1'b0;
         req_idx   <= '0;
         req_wdata <= '0;
         rdata_q   <= '0;
         proto_err <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (capture) begin
            req_wr    <= mem.mem_write;
            req_idx   <= mem.mem_addr[DEPTH_LOG2-1:0];
            req_wdata <= mem.mem_wdata;
            if (mem.mem_read && mem.mem_write) proto_err <= 1'b1;
         end
         if (rd_load) rdata_q <= mem_array[rd_idx];
      end
   end

   // Array is not reset; a reset during WAIT leaves state != RESP so nothing commits.
   always_ff @(posedge clk) begin
      if (state == RESP && req_wr) mem_array[req_idx] <= req_wdata;
   end

   assign mem.mem_ready = (state == RESP);
   assign mem.mem_rdata = rdata_q;

`ifdef MEM_RESP_STATS_EN
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         stat_reads  <= 32'd0;
         stat_writes <= 32'd0;
      end else if (state == RESP) begin
         if (req_wr) begin
            if (stat_writes != 32'hFFFF_FFFF) stat_writes <= stat_writes + 32'd1;
         end else begin
            if (stat_reads != 32'hFFFF_FFFF) stat_reads <= stat_reads + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: requests push expected completions,
// a negedge monitor pops and checks them against each mem_ready pulse.
module tb_mem_line_responder;
   localparam int ADDR_W     = 28;
   localparam int DATA_W     = 128;
   localparam int DEPTH_LOG2 = 10;
   localparam int LAT        = 4;

   logic clk = 1'b0;
   logic proc_reset_n;
   logic proto_err;
`ifdef MEM_RESP_STATS_EN
   logic [31:0] stat_reads, stat_writes;
`endif

   mem_line_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

   mem_line_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT)
   ) dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .mem          (mif.slave),
      .proto_err    (proto_err)
`ifdef MEM_RESP_STATS_EN
      ,
      .stat_reads   (stat_reads),
      .stat_writes  (stat_writes)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           due;
      logic         is_rd;
      logic [127:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   pulses  = 0;
   int   n_rd_exp = 0;
   int   n_wr_exp = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (proc_reset_n === 1'b1 && mif.mem_ready === 1'b1) begin
         pulses++;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: pulse at cycle %0d with nothing outstanding", cyc);
         end else begin
            e = sb.pop_front();
            check("ready_cycle", 128'(cyc), 128'(e.due));
            if (e.is_rd) check("read_data", mif.mem_rdata, e.rdata);
         end
      end
   end

   task automatic expect_resp(input logic rd, input logic wr, input logic [127:0] exp_rd);
      sb.push_back('{due: cyc + LAT, is_rd: rd && !wr, rdata: exp_rd});
      if (wr) n_wr_exp++;
      else n_rd_exp++;
   endtask

   task automatic wait_ready();
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (mif.mem_ready === 1'b1) got = 1;
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: no mem_ready within 20 cycles at cycle %0d", cyc);
         sb.delete();
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the TURN negedge.
   task automatic do_req(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wd, input logic [127:0] exp_rd, input bit keep);
      mif.mem_read  = rd;
      mif.mem_write = wr;
      mif.mem_addr  = addr;
      mif.mem_wdata = wd;
      expect_resp(rd, wr, exp_rd);
      wait_ready();
      @(negedge clk);
      if (!keep) begin
         mif.mem_read  = 1'b0;
         mif.mem_write = 1'b0;
      end
   endtask

   localparam logic [127:0] LINE_A = 128'hDEADBEEF_00000001_00000002_00000003;

   initial begin : stim
      int p0;
      proc_reset_n  = 1'b0;
      mif.mem_read  = 1'b0;
      mif.mem_write = 1'b0;
      mif.mem_addr  = '0;
      mif.mem_wdata = '0;
      repeat (3) @(negedge clk);
      proc_reset_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_ready", 128'(mif.mem_ready), 128'd0);
         check("idle_rdata", mif.mem_rdata, 128'd0);
         check("idle_proto_err", 128'(proto_err), 128'd0);
      end

      // Write then read at LATENCY=4; write leaves mem_rdata untouched
      do_req(1'b0, 1'b1, 28'h0000010, LINE_A, '0, 1'b0);
      check("rdata_after_write", mif.mem_rdata, 128'd0);
      @(negedge clk);
      do_req(1'b1, 1'b0, 28'h0000010, '0, LINE_A, 1'b0);
      @(negedge clk);

      // Held through TURN only: exactly one pulse
      p0 = pulses;
      do_req(1'b1, 1'b0, 28'h0000010, '0, LINE_A, 1'b1);
      @(negedge clk);
      mif.mem_read = 1'b0;
      repeat (12) @(negedge clk);
      check("held_single_pulse", 128'(pulses - p0), 128'd1);

      // Held into IDLE: a second capture and pulse at capture+LATENCY
      p0 = pulses;
      do_req(1'b1, 1'b0, 28'h0000010, '0, LINE_A, 1'b1);
      @(negedge clk);
      expect_resp(1'b1, 1'b0, LINE_A);
      wait_ready();
      @(negedge clk);
      mif.mem_read = 1'b0;
      repeat (3) @(negedge clk);
      check("held_retrigger_pulses", 128'(pulses - p0), 128'd2);

      // Aliasing: 0x400 and 0x000 share index 0; write keeps previous read data
      do_req(1'b0, 1'b1, 28'h0000400, 128'hA5, '0, 1'b0);
      check("rdata_hold_over_write", mif.mem_rdata, LINE_A);
      @(negedge clk);
      do_req(1'b1, 1'b0, 28'h0000000, '0, 128'hA5, 1'b0);
      @(negedge clk);

      // Protocol error: write wins, flag sticky
      check("proto_err_before", 128'(proto_err), 128'd0);
      do_req(1'b1, 1'b1, 28'h0000005, 128'h77, '0, 1'b0);
      check("proto_err_set", 128'(proto_err), 128'd1);
      @(negedge clk);
      do_req(1'b1, 1'b0, 28'h0000005, '0, 128'h77, 1'b0);
      check("proto_err_sticky", 128'(proto_err), 128'd1);
      @(negedge clk);

      // Known line for the reset test
      do_req(1'b0, 1'b1, 28'h0000020, 128'h1111, '0, 1'b0);
      @(negedge clk);
      do_req(1'b1, 1'b0, 28'h0000020, '0, 128'h1111, 1'b0);
      @(negedge clk);
`ifdef MEM_RESP_STATS_EN
      check("stat_reads", 128'(stat_reads), 128'(n_rd_exp));
      check("stat_writes", 128'(stat_writes), 128'(n_wr_exp));
`endif

      // Async reset two cycles after a write capture
      p0 = pulses;
      mif.mem_write = 1'b1;
      mif.mem_addr  = 28'h0000020;
      mif.mem_wdata = 128'h2222;
      @(posedge clk);
      @(posedge clk);
      #2 proc_reset_n = 1'b0;
      #1;
      check("reset_ready", 128'(mif.mem_ready), 128'd0);
      check("reset_rdata", mif.mem_rdata, 128'd0);
      check("reset_proto_err", 128'(proto_err), 128'd0);
`ifdef MEM_RESP_STATS_EN
      check("reset_stat_writes", 128'(stat_writes), 128'd0);
      check("reset_stat_reads", 128'(stat_reads), 128'd0);
`endif
      mif.mem_write = 1'b0;
      repeat (2) @(negedge clk);
      proc_reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("reset_no_pulse", 128'(pulses - p0), 128'd0);
      do_req(1'b1, 1'b0, 28'h0000020, '0, 128'h1111, 1'b0);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 128'(sb.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
